// File: rtl/dw_pe_array.sv
// Depthwise convolution PE array: POY x POX lanes, each multiplying its pixel by the
// broadcast kernel tap weight and accumulating NTAP taps into a rounded, saturated result.
module dw_pe_array #(
  parameter int unsigned DW    = 32,
  parameter int unsigned POY   = 3,
  parameter int unsigned POX   = 16,
  parameter int unsigned KSIZE = 4,
  parameter int unsigned FRAC  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wt_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]         wt_addr,
  input  logic [DW-1:0]                          wt_data,
  input  logic                                   dwpe_ena,
  input  logic [POY-1:0][POX-1:0][DW-1:0]        dwpixel_array,
  input  logic                                   blkend,
  output logic [POY-1:0][POX-1:0][DW-1:0]        dw_out,
  output logic                                   dw_valid,
  input  logic                                   dw_ready,
  output logic                                   ovf_err
);

  localparam int unsigned NTAP = KSIZE * KSIZE;
  localparam int unsigned TAPW = $clog2(NTAP);
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned ACCW = PW + $clog2(NTAP);

  localparam logic [TAPW-1:0] TAP_LAST = TAPW'(NTAP - 1);
  localparam logic signed [ACCW-1:0] RND  = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic        [DW-1:0]   wt_q   [NTAP];
  logic        [TAPW-1:0] tap_q;
  logic signed [PW-1:0]   prod_q [POY][POX];
  logic                   p_vld_q;
  logic                   p_last_q;
  logic                   p_first_q;
  logic signed [ACCW-1:0] acc_q  [POY][POX];

  logic signed [PW-1:0]   w_ext_c;
  logic signed [PW-1:0]   mul_c  [POY][POX];
  logic signed [ACCW-1:0] sum_c  [POY][POX];
  logic [POY-1:0][POX-1:0][DW-1:0] res_c;
  logic                   tile_ld_c;

  // Round half up at the FRAC boundary, then clamp to the DW signed range.
  function automatic logic [DW-1:0] sat_round(input logic signed [ACCW-1:0] s);
    logic signed [ACCW-1:0] r;
    logic        [DW-1:0]   o;
    r = (s + RND) >>> FRAC;
    if (r > SMAX)      o = SMAX[DW-1:0];
    else if (r < SMIN) o = SMIN[DW-1:0];
    else               o = r[DW-1:0];
    return o;
  endfunction

  always_comb begin
    w_ext_c   = $signed({{DW{wt_q[tap_q][DW-1]}}, wt_q[tap_q]});
    tile_ld_c = p_vld_q && p_last_q && !blkend;
    res_c     = '0;
    for (int y = 0; y < POY; y++) begin
      for (int x = 0; x < POX; x++) begin
        mul_c[y][x] = $signed({{DW{dwpixel_array[y][x][DW-1]}}, dwpixel_array[y][x]}) * w_ext_c;
        sum_c[y][x] = (p_first_q ? '0 : acc_q[y][x])
                    + $signed({{(ACCW-PW){prod_q[y][x][PW-1]}}, prod_q[y][x]});
        res_c[y][x] = sat_round(sum_c[y][x]);
      end
    end
  end

  // Weight register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) wt_q[i] <= '0;
    end else if (wt_we) begin
      wt_q[wt_addr] <= wt_data;
    end
  end

  // Stage 1: multiply and tag with tap position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q     <= '0;
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      p_first_q <= 1'b0;
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++) prod_q[y][x] <= '0;
    end else if (blkend) begin
      tap_q     <= '0;
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      p_first_q <= 1'b0;
    end else if (dwpe_ena) begin
      tap_q     <= (tap_q == TAP_LAST) ? '0 : tap_q + TAPW'(1);
      p_vld_q   <= 1'b1;
      p_last_q  <= (tap_q == TAP_LAST);
      p_first_q <= (tap_q == '0);
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++) prod_q[y][x] <= mul_c[y][x];
    end else begin
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      p_first_q <= 1'b0;
    end
  end

  // Stage 2: accumulate; the last tap clears the accumulator for the next tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++) acc_q[y][x] <= '0;
    end else if (blkend) begin
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++) acc_q[y][x] <= '0;
    end else if (p_vld_q) begin
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++) acc_q[y][x] <= p_last_q ? '0 : sum_c[y][x];
    end
  end

  // Output tile register and valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_out   <= '0;
      dw_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else if (tile_ld_c) begin
      dw_out   <= res_c;
      dw_valid <= 1'b1;
      if (dw_valid && !dw_ready) ovf_err <= 1'b1;
    end else if (dw_ready) begin
      dw_valid <= 1'b0;
    end
  end

endmodule
